branch_predictor: RTL

//  Dynamic branch predictor for the FETCH stage, upstream of IF_ID.
//  - Direct-mapped BHT of 2-bit saturating counters plus a BTB of branch targets.
//  - Read side: indexed by PC_curr; returns prediction/predicted_target combinationally in the same cycle.
//  - Write side: updated from DECODE using the IF_ID-carried PC and the prediction made at fetch time.

---
 rtl/branch_pred_pkg.sv | 22 ++
 rtl/bp_table.sv | 32 +++
 rtl/branch_predictor.sv | 99 +++++++++
 3 files changed

// File: rtl/branch_pred_pkg.sv
// Shared types and helpers for the branch predictor: 2-bit counter states
// and the saturating counter arithmetic used on BHT updates.
package branch_pred_pkg;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } bp_state_t;

  localparam int unsigned BP_ENTRIES_DEFAULT = 8;

  function automatic logic [1:0] sat_inc(input logic [1:0] s);
    return (s == STRONG_T) ? s : s + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] s);
    return (s == STRONG_NT) ? s : s - 2'd1;
  endfunction

endpackage

// File: rtl/bp_table.sv
// Async-reset register array with one combinational read port and one
// bit-masked synchronous write port.
module bp_table #(
  parameter  int unsigned WIDTH   = 1,
  parameter  int unsigned ENTRIES = 8,
  localparam int unsigned IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata,
  input  logic [IDX_W-1:0] waddr,
  input  logic [WIDTH-1:0] wmask,
  input  logic [WIDTH-1:0] wdata
);

  logic [WIDTH-1:0] mem [ENTRIES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        mem[i] <= '0;
      end
    end else if (|wmask) begin
      mem[waddr] <= (mem[waddr] & ~wmask) | (wdata & wmask);
    end
  end

  // Read sees the pre-edge contents: no write-to-read bypass.
  assign rdata = mem[raddr];

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped BHT of 2-bit counters plus BTB.
// Define BTB_TAG_EN to store per-entry tags and require a tag match for a hit.
module branch_predictor
  import branch_pred_pkg::*;
#(
  parameter int unsigned ENTRIES = BP_ENTRIES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] PC_curr,
  input  logic [15:0] IF_ID_PC_curr,
  input  logic [1:0]  IF_ID_prediction,
  input  logic        wen_BHT,
  input  logic        wen_BTB,
  input  logic        actual_taken,
  input  logic [15:0] actual_target,
  output logic [1:0]  prediction,
  output logic [15:0] predicted_target
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
`ifdef BTB_TAG_EN
  localparam int unsigned TAG_W = 15 - IDX_W;
  localparam int unsigned BTB_W = 16 + TAG_W;
`else
  localparam int unsigned BTB_W = 16;
`endif

  logic [IDX_W-1:0] ridx;
  logic [IDX_W-1:0] widx;
  logic [2:0]       bht_rdata;
  logic [2:0]       bht_wdata;
  logic [2:0]       bht_wmask;
  logic [BTB_W-1:0] btb_rdata;
  logic [BTB_W-1:0] btb_wdata;
  logic [BTB_W-1:0] btb_wmask;
  logic [1:0]       next_ctr;
  logic             hit;
  logic             unused_pc_bits;

  assign ridx = PC_curr[IDX_W:1];
  assign widx = IF_ID_PC_curr[IDX_W:1];

  // Update is based on the fetch-time counter, not the stored one.
  assign next_ctr  = actual_taken ? sat_inc(IF_ID_prediction) : sat_dec(IF_ID_prediction);

  // Valid lives with the counter; a BTB-only write sets it without touching the counter.
  assign bht_wdata = {1'b1, next_ctr};
  assign bht_wmask = {wen_BHT | wen_BTB, {2{wen_BHT}}};

`ifdef BTB_TAG_EN
  assign btb_wdata = {IF_ID_PC_curr[15:IDX_W+1], actual_target};
  assign hit       = bht_rdata[2] & (btb_rdata[BTB_W-1:16] == PC_curr[15:IDX_W+1]);
`else
  assign btb_wdata = actual_target;
  assign hit       = bht_rdata[2];
`endif
  assign btb_wmask = {BTB_W{wen_BTB}};

  bp_table #(
    .WIDTH   (3),
    .ENTRIES (ENTRIES)
  ) iBHT (
    .clk   (clk),
    .rst_n (rst_n),
    .raddr (ridx),
    .rdata (bht_rdata),
    .waddr (widx),
    .wmask (bht_wmask),
    .wdata (bht_wdata)
  );

  bp_table #(
    .WIDTH   (BTB_W),
    .ENTRIES (ENTRIES)
  ) iBTB (
    .clk   (clk),
    .rst_n (rst_n),
    .raddr (ridx),
    .rdata (btb_rdata),
    .waddr (widx),
    .wmask (btb_wmask),
    .wdata (btb_wdata)
  );

  always_comb begin
    prediction       = '0;
    predicted_target = '0;
    if (hit) begin
      prediction       = bht_rdata[1:0];
      predicted_target = btb_rdata[15:0];
    end
  end

  // PCs are word aligned; bit 0 never participates.
  assign unused_pc_bits = ^{PC_curr[15:IDX_W+1], PC_curr[0],
                            IF_ID_PC_curr[15:IDX_W+1], IF_ID_PC_curr[0]};

endmodule
